// File: rtl/aes_ctrl_pkg.sv
// aes_ctrl_pkg: shared types and constants for the AES round sequencer.
//   state_t   - controller states (IDLE, KEYPRE, LOAD, ROUND, DONE)
//   NR_*      - round counts for 128/192/256-bit keys
//   CNT_W_DEF - default round counter width
package aes_ctrl_pkg;
    typedef enum logic [2:0] {IDLE, KEYPRE, LOAD, ROUND, DONE} state_t;
    localparam int NR_128    = 10;
    localparam int NR_192    = 12;
    localparam int NR_256    = 14;
    localparam int CNT_W_DEF = 4;
endpackage

// File: rtl/aes_round_cnt.sv
// aes_round_cnt: round counter with clear, saturating increment and terminal flag.
//   clk, rst_n - clock, asynchronous active-low reset
//   clr        - synchronous clear to 0 (wins over inc)
//   inc        - increment by one, saturating at NR
//   cnt        - current count
//   term       - cnt == NR
module aes_round_cnt #(
    parameter int NR    = 10,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt,
    output logic             term
);
    assign term = cnt == CNT_W'(NR);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (inc && !term)
            cnt <= cnt + 1'b1;
    end
endmodule

// File: rtl/aes_round_ctrl.sv
// aes_round_ctrl: sequencer for an iterative one-round-per-clock AES datapath.
//   Optional feature: define AES_DECRYPT_EN to add in_decrypt / dp_inv and the KEYPRE state.
//   clk, rst_n            - clock, asynchronous active-low reset
//   in_valid/in_ready     - block request handshake
//   out_valid/out_ready   - result handshake
//   dp_load               - load state with block XOR round key 0
//   dp_round_en           - apply one round
//   dp_key_step           - advance (or, when decrypting in ROUND, rewind) the key schedule
//   dp_last_round         - final round, MixColumns bypassed
//   round_idx             - current round number
//   busy                  - controller not idle
//   in_decrypt, dp_inv    - (AES_DECRYPT_EN only) decrypt request / inverse datapath select
module aes_round_ctrl
    import aes_ctrl_pkg::*;
#(
    parameter int NR    = NR_128,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
`ifdef AES_DECRYPT_EN
    input  logic             in_decrypt,
    output logic             dp_inv,
`endif
    output logic             dp_load,
    output logic             dp_round_en,
    output logic             dp_key_step,
    output logic             dp_last_round,
    output logic [CNT_W-1:0] round_idx,
    output logic             busy
);
    state_t state, state_nxt;
    logic   live, accept, clr, inc, term;

    // live keeps in_ready low while reset is asserted and rises on the first clock after release
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            live  <= 1'b0;
        end else begin
            state <= state_nxt;
            live  <= 1'b1;
        end
    end

    assign accept = live && state == IDLE && in_valid;

`ifdef AES_DECRYPT_EN
    logic inv;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            inv <= 1'b0;
        else if (accept)
            inv <= in_decrypt;
    end
    assign dp_inv = inv && (state == LOAD || state == ROUND || state == DONE);
`endif

    always_comb begin
        state_nxt = IDLE;
        case (state)
`ifdef AES_DECRYPT_EN
            IDLE:    state_nxt = accept ? (in_decrypt ? KEYPRE : LOAD) : IDLE;
            KEYPRE:  state_nxt = term ? LOAD : KEYPRE;
`else
            IDLE:    state_nxt = accept ? LOAD : IDLE;
`endif
            LOAD:    state_nxt = ROUND;
            ROUND:   state_nxt = term ? DONE : ROUND;
            DONE:    state_nxt = out_ready ? IDLE : DONE;
            default: state_nxt = IDLE;
        endcase
    end

    // Counter follows the next state: cleared entering IDLE/LOAD, counting while
    // entering or staying in KEYPRE/ROUND, and saturated at NR through DONE.
    assign clr = state_nxt == IDLE || state_nxt == LOAD;
    assign inc = state_nxt == KEYPRE || state_nxt == ROUND;

    aes_round_cnt #(.NR(NR), .CNT_W(CNT_W)) u_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .inc   (inc),
        .cnt   (round_idx),
        .term  (term)
    );

    always_comb begin
        in_ready      = live && state == IDLE;
        out_valid     = state == DONE;
        dp_load       = state == LOAD;
        dp_round_en   = state == ROUND;
        dp_key_step   = state == ROUND || state == KEYPRE;
        dp_last_round = state == ROUND && term;
        busy          = state != IDLE;
    end
endmodule

// File: tb/tb_aes_round_ctrl.sv
// tb_aes_round_ctrl: directed self-checking bench for aes_round_ctrl (NR=10).
module tb_aes_round_ctrl;
    localparam int NR = 10;

    logic       clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic       in_ready, out_valid, dp_load, dp_round_en, dp_key_step, dp_last_round, busy;
    logic [3:0] round_idx;
`ifdef AES_DECRYPT_EN
    logic       in_decrypt = 1'b0, dp_inv;
`endif
    int         n_checks = 0, n_fail = 0;

    always #5 clk = ~clk;

    aes_round_ctrl #(.NR(NR), .CNT_W(4)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
`ifdef AES_DECRYPT_EN
        .in_decrypt    (in_decrypt),
        .dp_inv        (dp_inv),
`endif
        .dp_load       (dp_load),
        .dp_round_en   (dp_round_en),
        .dp_key_step   (dp_key_step),
        .dp_last_round (dp_last_round),
        .round_idx     (round_idx),
        .busy          (busy)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int flags();
        return {in_ready, out_valid, dp_load, dp_round_en, dp_key_step, dp_last_round, busy};
    endfunction

    initial begin
        int hits, first, second, third, ov;
        // reset
        #2;
        check("rst_flags", flags(), 0);
        check("rst_idx", round_idx, 0);
        tick();
        tick();
        check("rst_hold_flags", flags(), 0);
        @(negedge clk) rst_n = 1'b1;
        tick();
        check("rel_in_ready", in_ready, 1);
        check("rel_busy", busy, 0);
        check("rel_idx", round_idx, 0);

        // single encrypt
        out_ready = 1'b1;
        in_valid  = 1'b1;
        tick();
        in_valid = 1'b0;
        check("enc_load", dp_load, 1);
        check("enc_load_idx", round_idx, 0);
        check("enc_load_ready", in_ready, 0);
        check("enc_load_rnd", dp_round_en, 0);
`ifdef AES_DECRYPT_EN
        check("enc_inv", dp_inv, 0);
`endif
        for (int r = 1; r <= NR; r++) begin
            tick();
            check($sformatf("enc_rnd%0d_flags", r),
                  {dp_load, dp_round_en, dp_key_step, dp_last_round, out_valid}, {4'b0110, 1'b0} | ((r == NR) ? 2 : 0));
            check($sformatf("enc_rnd%0d_idx", r), round_idx, r);
        end
        tick();
        check("enc_done_valid", out_valid, 1);
        check("enc_done_strobes", {dp_load, dp_round_en, dp_key_step, dp_last_round}, 0);
        check("enc_done_idx", round_idx, NR);
        tick();
        check("enc_idle_ready", in_ready, 1);
        check("enc_idle_idx", round_idx, 0);
        check("enc_idle_busy", busy, 0);

        // backpressure
        out_ready = 1'b0;
        in_valid  = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (NR + 1) tick();
        for (int k = 0; k < 6; k++) begin
            check($sformatf("bp_valid%0d", k), out_valid, 1);
            check($sformatf("bp_idx%0d", k), round_idx, NR);
            if (k < 5) tick();
        end
        out_ready = 1'b1;
        tick();
        check("bp_idle_ready", in_ready, 1);
        check("bp_idle_valid", out_valid, 0);

        // back-to-back
        in_valid = 1'b1;
        hits = 0; first = -1; second = -1; third = -1;
        for (int c = 0; c < 39; c++) begin
            if (in_ready) begin
                if (hits == 0) first = c;
                else if (hits == 1) second = c;
                else third = c;
                hits++;
            end
            tick();
        end
        in_valid = 1'b0;
        check("b2b_count", hits, 3);
        check("b2b_gap1", second - first, NR + 3);
        check("b2b_gap2", third - second, NR + 3);
        tick();
        check("b2b_idle", in_ready, 1);

        // mid-run reset
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (5) tick();
        check("mid_idx_before", round_idx, 5);
        rst_n = 1'b0;
        #1;
        check("mid_rst_flags", flags(), 0);
        check("mid_rst_idx", round_idx, 0);
        tick();
        @(negedge clk) rst_n = 1'b1;
        ov = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            ov += out_valid;
        end
        check("mid_no_valid", ov, 0);
        check("mid_idle", in_ready, 1);

`ifdef AES_DECRYPT_EN
        // decrypt
        in_valid   = 1'b1;
        in_decrypt = 1'b1;
        tick();
        in_valid   = 1'b0;
        in_decrypt = 1'b0;
        for (int k = 1; k <= NR; k++) begin
            check($sformatf("dec_pre%0d_flags", k), {dp_key_step, dp_round_en, dp_load}, 3'b100);
            check($sformatf("dec_pre%0d_idx", k), round_idx, k);
            tick();
        end
        check("dec_load", dp_load, 1);
        check("dec_load_inv", dp_inv, 1);
        check("dec_load_idx", round_idx, 0);
        for (int r = 1; r <= NR; r++) begin
            tick();
            check($sformatf("dec_rnd%0d", r), {dp_round_en, dp_inv, dp_last_round}, {2'b11, r == NR});
            check($sformatf("dec_rnd%0d_idx", r), round_idx, r);
        end
        tick();
        check("dec_done_valid", out_valid, 1);
        check("dec_done_inv", dp_inv, 1);
        tick();
        check("dec_idle_inv", dp_inv, 0);
        check("dec_idle_ready", in_ready, 1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
